// File: rtl/sub_bytes_pipe_if.sv
// Handshake bundle for sub_bytes_pipe: upstream (in_*) and downstream (out_*) channels.
// master = the side that feeds transfers in and consumes results; slave = the engine.
interface sub_bytes_pipe_if #(
    parameter int LANES = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic [8*LANES-1:0]   in_data;
    logic                 in_inv;
    logic                 out_valid;
    logic                 out_ready;
    logic [8*LANES-1:0]   out_data;
    logic                 out_inv;

    modport master (
        output in_valid, in_data, in_inv, out_ready,
        input  in_ready, out_valid, out_data, out_inv
    );

    modport slave (
        input  in_valid, in_data, in_inv, out_ready,
        output in_ready, out_valid, out_data, out_inv
    );
endinterface

// File: rtl/sub_bytes_pipe.sv
// Two-stage pipelined AES SubBytes engine, LANES bytes per transfer, optional inverse S-box.
// Handshake: a transfer moves on a channel only in a cycle where valid && ready are both 1.
module sub_bytes_pipe #(
    parameter int LANES  = 16,
    parameter bit INV_EN = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    sub_bytes_pipe_if.slave     bus
);
    localparam int W = 8 * LANES;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = xtime(t);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254; a = 0 naturally yields 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] sq;
        r  = 8'h01;
        sq = a;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox_fwd(input logic [7:0] a);
        logic [7:0] x;
        x = gf_inv(a);
        return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]}
                 ^ {x[3:0], x[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] sbox_inv(input logic [7:0] s);
        logic [7:0] x;
        x = {s[1:0], s[7:2]} ^ {s[4:0], s[7:5]} ^ {s[6:0], s[7]} ^ 8'h05;
        return gf_inv(x);
    endfunction

    logic           r_a_valid;
    logic           r_a_inv;
    logic [W-1:0]   r_a_data;
    logic           r_b_valid;
    logic           r_b_inv;
    logic [W-1:0]   r_b_data;

    logic           w_b_adv;
    logic           w_a_adv;
    logic           w_in_fire;
    logic           w_in_inv;
    logic [W-1:0]   w_sub;

    // Both stages may shift in the same cycle, so a full pipe still accepts while draining.
    assign w_b_adv   = !r_b_valid || bus.out_ready;
    assign w_a_adv   = !r_a_valid || w_b_adv;
    assign w_in_fire = bus.in_valid && w_a_adv;
    assign w_in_inv  = INV_EN ? bus.in_inv : 1'b0;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        if (INV_EN) begin : g_dual
            assign w_sub[8*g +: 8] = r_a_inv ? sbox_inv(r_a_data[8*g +: 8])
                                             : sbox_fwd(r_a_data[8*g +: 8]);
        end else begin : g_fwd
            assign w_sub[8*g +: 8] = sbox_fwd(r_a_data[8*g +: 8]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a_valid <= 1'b0;
            r_a_inv   <= 1'b0;
            r_a_data  <= '0;
            r_b_valid <= 1'b0;
            r_b_inv   <= 1'b0;
            r_b_data  <= '0;
        end else begin
            if (w_a_adv) begin
                r_a_valid <= w_in_fire;
                if (w_in_fire) begin
                    r_a_data <= bus.in_data;
                    r_a_inv  <= w_in_inv;
                end
            end
            // Payload only loads with a valid beat so stalled output stays put.
            if (w_b_adv) begin
                r_b_valid <= r_a_valid;
                if (r_a_valid) begin
                    r_b_data <= w_sub;
                    r_b_inv  <= r_a_inv;
                end
            end
        end
    end

    assign bus.in_ready  = w_a_adv;
    assign bus.out_valid = r_b_valid;
    assign bus.out_data  = r_b_data;
    assign bus.out_inv   = r_b_inv;
endmodule
